// File: rtl/dec_pkg.sv
// Shared types and helpers for the one-hot decoder slice.
//   state_t    : decoder FSM state (IDLE, DRIVE)
//   IDX_W_DEF  : default index width
//   OUT_W_DEF  : default one-hot width (2**IDX_W_DEF)
//   onehot_of  : 1 << idx at the default widths; shared with the bench scoreboard
package dec_pkg;
  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  localparam int IDX_W_DEF = 3;
  localparam int OUT_W_DEF = 1 << IDX_W_DEF;

  function automatic logic [OUT_W_DEF-1:0] onehot_of(input logic [IDX_W_DEF-1:0] idx);
    return OUT_W_DEF'(1) << idx;
  endfunction
endpackage

// File: rtl/hold_timer.sv
// Hold-length counter for one decoded output.
//   clk, rst : clock, async active-high reset
//   load     : restart the hold (a new value is being driven next cycle)
//   clear    : return to zero (output is being dropped)
//   run      : output is being driven; advance toward terminal count
//   tc       : cnt == HOLD-1, last cycle of the current hold
module hold_timer #(
  parameter int HOLD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic run,
  output logic tc
);
  localparam int CW = $clog2(HOLD + 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(HOLD - 1));

  // Parks at HOLD-1 rather than wrapping, so tc stays stable until the
  // top either reloads or clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (load || clear) cnt <= '0;
    else if (run && !tc)    cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/onehot_decoder_hold.sv
// Registered N-to-2^N decoder with valid/ready input and programmable hold.
//   clk, rst   : clock, async active-high reset
//   en         : acceptance enable (gates in_ready only)
//   flush      : synchronous clear of the active output
//   in_valid   : index request valid
//   in_ready   : request can be accepted this cycle
//   idx        : binary index, sampled only on accept
//   onehot     : registered decoded vector, zero or one-hot
//   out_valid  : registered, mirrors |onehot
//   busy       : FSM is in DRIVE
//   acc_cnt    : accepted-request count, wraps
module onehot_decoder_hold
  import dec_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int HOLD  = 2,
  parameter int CNT_W = 8,
  localparam int OUT_W = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] onehot,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] acc_cnt
);
  state_t state;
  logic   tc;
  logic   accept;
  logic   drive_end;

  // Ready in IDLE, or on the last hold cycle so consecutive outputs abut.
  assign in_ready  = !rst && en && !flush && ((state == IDLE) || ((state == DRIVE) && tc));
  assign accept    = in_valid && in_ready;
  assign drive_end = (state == DRIVE) && tc && !accept;
  assign busy      = (state == DRIVE);

  hold_timer #(.HOLD(HOLD)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .clear (flush || drive_end),
    .run   (state == DRIVE),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      onehot    <= '0;
      out_valid <= 1'b0;
      acc_cnt   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      onehot    <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      state     <= DRIVE;
      onehot    <= OUT_W'(1) << idx;
      out_valid <= 1'b1;
      acc_cnt   <= acc_cnt + 1'b1;
    end else if (drive_end) begin
      state     <= IDLE;
      onehot    <= '0;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_onehot_decoder_hold.sv
// Scoreboard bench: two decoders (HOLD=2 and HOLD=1) share one stimulus
// stream. A reference model pushes HOLD copies of each expected one-hot
// value per accept; a negedge monitor pops one entry per driven cycle.
module tb_onehot_decoder_hold;
  import dec_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [2:0] idx = '0;

  logic       rdy_a, ov_a, bz_a, rdy_b, ov_b, bz_b;
  logic [7:0] oh_a, oh_b, acc_a, acc_b;

  int total = 0, bad = 0;
  int hold_of [2] = '{2, 1};
  int acc_exp [2] = '{0, 0};
  bit rdy_exp [2] = '{0, 0};
  logic [7:0] qa[$], qb[$];

  always #5 clk = ~clk;

  onehot_decoder_hold #(.IDX_W(3), .HOLD(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy_a), .idx(idx), .onehot(oh_a), .out_valid(ov_a),
    .busy(bz_a), .acc_cnt(acc_a));

  onehot_decoder_hold #(.IDX_W(3), .HOLD(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy_b), .idx(idx), .onehot(oh_b), .out_valid(ov_b),
    .busy(bz_b), .acc_cnt(acc_b));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  // Reference model: an accept replaces any pending tail with HOLD copies.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete(); qb.delete();
      acc_exp = '{0, 0};
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (flush) begin
          if (k == 0) qa.delete(); else qb.delete();
        end else if (in_valid && rdy_exp[k]) begin
          if (k == 0) qa.delete(); else qb.delete();
          for (int h = 0; h < hold_of[k]; h++)
            if (k == 0) qa.push_back(onehot_of(idx)); else qb.push_back(onehot_of(idx));
          acc_exp[k] = acc_exp[k] + 1;
        end
      end
    end
  end

  // Monitor: ready when idle or on the last queued cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic       r, v, b;
      logic [7:0] o, a, e;
      r = (k == 0) ? rdy_a : rdy_b;
      v = (k == 0) ? ov_a  : ov_b;
      b = (k == 0) ? bz_a  : bz_b;
      o = (k == 0) ? oh_a  : oh_b;
      a = (k == 0) ? acc_a : acc_b;
      rdy_exp[k] = !rst && en && !flush && (qsize(k) <= 1);
      chk("in_ready", k, 32'(r), 32'(rdy_exp[k]));
      chk("acc_cnt", k, 32'(a), 32'(acc_exp[k] % 256));
      chk("onehot0", k, 32'($onehot0(o)), 32'd1);
      chk("busy_eq_valid", k, 32'(b), 32'(v));
      if (qsize(k) > 0) begin
        e = (k == 0) ? qa.pop_front() : qb.pop_front();
        chk("out_valid", k, 32'(v), 32'd1);
        chk("onehot", k, 32'(o), 32'(e));
      end else begin
        chk("out_valid_idle", k, 32'(v), 32'd0);
        chk("onehot_idle", k, 32'(o), 32'd0);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset with en high: ready must stay low while rst is asserted.
    en = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);

    // Single request idx=2.
    in_valid = 1'b1; idx = 3'd2; step(1);
    in_valid = 1'b0; idx = 3'd6; step(4);

    // Back-to-back idx=7 then idx=0, then same index repeated.
    in_valid = 1'b1; idx = 3'd7; step(2);
    idx = 3'd0; step(2);
    idx = 3'd3; step(4);
    in_valid = 1'b0; step(3);

    // Enable gating during a hold.
    in_valid = 1'b1; idx = 3'd7; step(1);
    en = 1'b0; idx = 3'd5; step(4);
    en = 1'b1; step(1);
    in_valid = 1'b0; step(3);

    // Flush in the first drive cycle with a request pending.
    in_valid = 1'b1; idx = 3'd4; step(1);
    flush = 1'b1; step(1);
    flush = 1'b0; in_valid = 1'b0; step(3);

    // Async reset in the middle of a hold.
    in_valid = 1'b1; idx = 3'd1; step(1);
    in_valid = 1'b0;
    do_reset();
    step(2);

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom % 8) != 0;
      flush    = ($urandom % 16) == 0;
      in_valid = ($urandom % 3) != 0;
      idx      = 3'($urandom);
      if (($urandom % 200) == 0) do_reset();
      else step(1);
    end
    en = 1'b1; flush = 1'b0; in_valid = 1'b0;
    step(3);

    // Wrap: 256 back-to-back accepts on the HOLD=1 instance.
    do_reset();
    step(1);
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; idx = 3'(i % 8);
      step(1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("acc_wrap", 1, 32'(acc_b), 32'd0);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onehot_decoder_hold.md
Name: onehot_decoder_hold

Overview:
Registered N-to-2^N decoder with a valid/ready input handshake. It turns a binary index back into a one-hot line vector, driving the companion direction of the 8-to-3 priority encoder path. Each decoded line is held for a programmable number of cycles, and back-to-back requests are supported with no gap cycle. It sits between index producers (arbiters, encoders) and per-line consumers that need a clean one-hot strobe of fixed width.

Parameters:
IDX_W, 3, index width; output width OUT_W = 2**IDX_W (localparam, not overridable).
HOLD, 2, cycles each decoded one-hot value stays asserted; legal range 1..255.
CNT_W, 8, width of the accepted-request counter.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  acceptance enable; gates in_ready only.
flush  in  1  synchronous clear of the active output.
in_valid  in  1  index request valid.
in_ready  out  1  block can accept this cycle.
idx  in  IDX_W  binary index to decode.
onehot  out  OUT_W  registered decoded vector; zero or exactly one bit set.
out_valid  out  1  registered; equals |onehot at all times.
busy  out  1  state == DRIVE.
acc_cnt  out  CNT_W  count of accepted requests, wraps.

Behaviour:
- Reset (async assert, sync release): state=IDLE, onehot=0, out_valid=0, hold count=0, acc_cnt=0. in_ready=0 while rst is high.
- in_ready (combinational) = !rst & en & !flush & (state==IDLE | (state==DRIVE & cnt==HOLD-1)).
- Accept = in_valid & in_ready at a rising edge. Latency 1: next cycle onehot = 1<<idx, out_valid=1, cnt=0, state=DRIVE, acc_cnt+1.
- States:
  - IDLE: on accept, go to DRIVE. Otherwise stay, onehot=0.
  - DRIVE: cnt increments each cycle. At cnt==HOLD-1 with no accept, go to IDLE and set onehot=0 and out_valid=0 next cycle. At cnt==HOLD-1 with accept, load the new onehot directly, cnt=0, stay in DRIVE; no zero cycle between outputs.
- Same index re-accepted back-to-back: onehot unchanged, hold restarts, out_valid stays 1.
- HOLD=1: in_ready stays high in DRIVE, so a continuous in_valid stream produces a new one-hot value every cycle.
- en=0: no new acceptance. An output already in DRIVE runs its full hold and then returns to IDLE. in_valid/idx may be held; the request is taken on the first cycle en=1 and in_ready=1.
- flush=1: next cycle state=IDLE, onehot=0, out_valid=0, cnt=0. No accept occurs in a flush cycle (in_ready is low). acc_cnt is not changed by flush.
- acc_cnt wraps from 2**CNT_W-1 to 0 and never saturates.
- Reset asserted mid-DRIVE: outputs clear immediately (async). No partial hold resumes after release.
- idx is sampled only on accept. idx changes while not accepting have no effect.
- Invariants for the bench to assert: $onehot0(onehot); out_valid == |onehot; busy == out_valid.

Decomposition:
- Shared package dec_pkg:
  - state enum typedef (IDLE, DRIVE);
  - default IDX_W constant;
  - function onehot_of(idx) returning 1<<idx, for reuse by the bench scoreboard.
- One sub-module is natural: hold_timer. It is a load/count/terminal-count counter of width $clog2(HOLD+1), with inputs load and clear and output tc = (cnt==HOLD-1).
- FSM, handshake and acc_cnt stay in the top module.

Test Plan:
1. Reset: rst=1 with en=1 -> onehot=8'h00, out_valid=0, acc_cnt=0, in_ready=0. Release rst -> in_ready=1.
2. Single request, HOLD=2: idx=3'd2 valid at cycle k -> onehot=8'b00000100 at k+1 and k+2, 8'h00 at k+3, acc_cnt=1.
3. Back-to-back, HOLD=2: in_valid held with idx=7 then idx=0 -> onehot 8'h80 for 2 cycles then 8'h01 for 2 cycles with no zero cycle; in_ready=0 during the first DRIVE cycle of each.
4. Enable gating: set en=0 during 8'h80 hold with in_valid=1 and idx=5 -> 8'h80 finishes and returns to 8'h00. Raise en=1 at cycle m -> onehot=8'h20 at m+1.
5. Flush: flush=1 in the first DRIVE cycle of 8'h10 with in_valid=1 -> onehot=8'h00 next cycle, state IDLE, acc_cnt unchanged.
6. Wrap and HOLD=1 stream: 256 consecutive accepts of idx=0..7 cycling -> onehot steps 01,02,04..80 one per cycle, and acc_cnt returns to 0 after the 256th accept.
